// File: rtl/mcb_line_xfer.sv
// Cache-line mover between the line buffer and one MCB user port.
// Evicts (buffer -> write FIFO -> write cmd) and fills (read cmd -> read FIFO -> buffer).
module mcb_line_xfer #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  parameter int LADDR_W   = 15,
  parameter int BADDR_W   = 30,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_req,
  input  logic                         rd_req,
  input  logic [LADDR_W-1:0]           waddr,
  input  logic [LADDR_W-1:0]           raddr,
  output logic                         wr_busy,
  output logic                         rd_busy,
  output logic                         rd_err,
  output logic [$clog2(BURST_LEN)-1:0] buf_addr,
  output logic                         buf_en,
  output logic                         buf_we,
  output logic [DATA_W-1:0]            buf_wdata,
  input  logic [DATA_W-1:0]            buf_rdata,
  output logic                         cmd_en,
  output logic [2:0]                   cmd_instr,
  output logic [5:0]                   cmd_bl,
  output logic [BADDR_W-1:0]           cmd_byte_addr,
  output logic                         wr_en,
  output logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_full,
  input  logic                         wr_empty,
  output logic                         rd_en,
  input  logic [DATA_W-1:0]            rd_data,
  input  logic                         rd_empty
);

  localparam int AW  = $clog2(BURST_LEN);
  localparam int CW  = AW + 1;
  localparam int OFF = $clog2(BURST_LEN * DATA_W / 8);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_LEN  = CW'(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, WFILL, WCMD, WDRAIN, RCMD, RDATA
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          wr_sync_q, rd_sync_q;
  logic [CW-1:0]       rcnt_q, rcnt_d;
  logic [CW-1:0]       pcnt_q, pcnt_d;
  logic                rvld_q, rvld_d;
  logic                hold_v_q, hold_v_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic                wr_busy_q, wr_busy_d;
  logic                rd_busy_q, rd_busy_d;
  logic                rd_err_q, rd_err_d;
  logic                wr_go, rd_go, push;

  assign wr_go   = wr_sync_q[1];
  assign rd_go   = rd_sync_q[1];
  assign wr_busy = wr_busy_q;
  assign rd_busy = rd_busy_q;
  assign rd_err  = rd_err_q;
  assign cmd_bl  = 6'(BURST_LEN - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_sync_q <= '0;
      rd_sync_q <= '0;
      rcnt_q    <= '0;
      pcnt_q    <= '0;
      rvld_q    <= 1'b0;
      hold_v_q  <= 1'b0;
      hold_q    <= '0;
      wd_q      <= '0;
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_sync_q <= {wr_sync_q[0], wr_req};
      rd_sync_q <= {rd_sync_q[0], rd_req};
      rcnt_q    <= rcnt_d;
      pcnt_q    <= pcnt_d;
      rvld_q    <= rvld_d;
      hold_v_q  <= hold_v_d;
      hold_q    <= hold_d;
      wd_q      <= wd_d;
      wr_busy_q <= wr_busy_d;
      rd_busy_q <= rd_busy_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    pcnt_d        = pcnt_q;
    rvld_d        = 1'b0;
    hold_v_d      = hold_v_q;
    hold_d        = hold_q;
    wd_d          = '0;
    wr_busy_d     = wr_busy_q;
    rd_busy_d     = rd_busy_q;
    rd_err_d      = rd_err_q;
    push          = 1'b0;
    buf_addr      = '0;
    buf_en        = 1'b0;
    buf_we        = 1'b0;
    buf_wdata     = '0;
    cmd_en        = 1'b0;
    cmd_instr     = 3'b000;
    cmd_byte_addr = '0;
    wr_en         = 1'b0;
    wr_data       = '0;
    rd_en         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_go && wr_empty) begin
          state_d   = WFILL;
          wr_busy_d = 1'b1;
          rcnt_d    = '0;
          pcnt_d    = '0;
          hold_v_d  = 1'b0;
        end else if (rd_go) begin
          state_d   = RCMD;
          rd_busy_d = 1'b1;
          rd_err_d  = 1'b0;
        end
      end

      WFILL: begin
        // A read issued just before the FIFO filled is parked in hold_q.
        push    = (rvld_q | hold_v_q) & ~wr_full;
        wr_en   = push;
        if (push)
          wr_data = hold_v_q ? hold_q : buf_rdata;
        if (rvld_q && wr_full) begin
          hold_v_d = 1'b1;
          hold_d   = buf_rdata;
        end else if (push) begin
          hold_v_d = 1'b0;
        end
        if (push)
          pcnt_d = pcnt_q + 1'b1;
        if (!wr_full && rcnt_q < CNT_LEN) begin
          buf_en   = 1'b1;
          buf_addr = rcnt_q[AW-1:0];
          rcnt_d   = rcnt_q + 1'b1;
          rvld_d   = 1'b1;
        end
        if (push && pcnt_q == CNT_LAST)
          state_d = WCMD;
      end

      WCMD: begin
        cmd_en        = 1'b1;
        cmd_instr     = 3'b000;
        cmd_byte_addr = BADDR_W'(waddr) << OFF;
        state_d       = WDRAIN;
      end

      WDRAIN: begin
        if (wr_empty) begin
          wr_busy_d = 1'b0;
          if (rd_go) begin
            state_d   = RCMD;
            rd_busy_d = 1'b1;
            rd_err_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      RCMD: begin
        cmd_en        = 1'b1;
        cmd_instr     = 3'b001;
        cmd_byte_addr = BADDR_W'(raddr) << OFF;
        rcnt_d        = '0;
        state_d       = RDATA;
      end

      RDATA: begin
        if (!rd_empty) begin
          rd_en     = 1'b1;
          buf_en    = 1'b1;
          buf_we    = 1'b1;
          buf_wdata = rd_data;
          buf_addr  = rcnt_q[AW-1:0];
          rcnt_d    = rcnt_q + 1'b1;
          if (rcnt_q == CNT_LAST) begin
            state_d   = IDLE;
            rd_busy_d = 1'b0;
          end
        end else if (TIMEOUT != 0) begin
          if (wd_q == WD_LAST) begin
            state_d   = IDLE;
            rd_busy_d = 1'b0;
            rd_err_d  = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcb_line_xfer.sv
// Directed bench for mcb_line_xfer: evict, fill, back-to-back,
// write back-pressure, read watchdog and mid-burst reset.
module tb_mcb_line_xfer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req, rd_req;
  logic [14:0]   waddr, raddr;
  logic          wr_busy, rd_busy, rd_err;
  logic [3:0]    buf_addr;
  logic          buf_en, buf_we;
  logic [127:0]  buf_wdata, buf_rdata;
  logic          cmd_en;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [29:0]   cmd_byte_addr;
  logic          wr_en;
  logic [127:0]  wr_data;
  logic          wr_full, wr_empty;
  logic          rd_en;
  logic [127:0]  rd_data;
  logic          rd_empty;

  always #5 clk = ~clk;

  mcb_line_xfer #(.TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .rd_req(rd_req),
    .waddr(waddr), .raddr(raddr),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .rd_err(rd_err),
    .buf_addr(buf_addr), .buf_en(buf_en), .buf_we(buf_we),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr),
    .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
  );

  function automatic logic [127:0] pat_w(input int i);
    return {4{32'hA500_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] pat_r(input int i);
    return {4{32'h5A00_0000 + 32'(i)}};
  endfunction

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory-side models and logs
  logic [127:0] mem [16];
  logic [127:0] wlog [32];
  logic [3:0]   blog_a [32];
  logic [127:0] blog_d [32];
  logic [2:0]   clog_i [4];
  logic [29:0]  clog_a [4];
  int wn, bn, cn, ovf, rd_idx, rd_lim;
  logic clr;

  assign rd_empty = (rd_idx >= rd_lim);
  assign rd_data  = pat_r(rd_idx);

  always @(posedge clk) begin
    if (clr) begin
      wn <= 0; bn <= 0; cn <= 0; ovf <= 0; rd_idx <= 0;
    end else begin
      if (wr_en) begin
        if (wn < 32) wlog[wn] <= wr_data;
        wn <= wn + 1;
        if (wr_full) ovf <= ovf + 1;
      end
      if (cmd_en) begin
        if (cn < 4) begin
          clog_i[cn] <= cmd_instr;
          clog_a[cn] <= cmd_byte_addr;
        end
        cn <= cn + 1;
      end
      if (buf_en && buf_we) begin
        if (bn < 32) begin
          blog_a[bn] <= buf_addr;
          blog_d[bn] <= buf_wdata;
        end
        bn <= bn + 1;
      end
      if (rd_en) rd_idx <= rd_idx + 1;
    end
    if (buf_en && !buf_we) buf_rdata <= mem[buf_addr];
  end

  task automatic do_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = pat_w(i);
    wr_req = 0; rd_req = 0; waddr = '0; raddr = '0;
    wr_full = 0; wr_empty = 1; rd_lim = 0; clr = 1;
    buf_rdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_rd_err",  rd_err, 0);
    chk("rst_cmd_en",  cmd_en, 0);
    chk("rst_cmd_bl",  cmd_bl, 15);
    chk("rst_strobes", {buf_en, wr_en, rd_en}, 0);
    reset = 0;
    clr = 0;

    // evict 0x1234
    waddr = 15'h1234; wr_req = 1;
    for (n = 0; n < 50 && !wr_busy; n++) @(negedge clk);
    chk("w1_busy_rise", wr_busy, 1);
    wr_req = 0;
    for (n = 0; n < 100 && cn == 0; n++) @(negedge clk);
    chk("w1_cmd_seen", cn, 1);
    wr_empty = 0;
    repeat (3) @(negedge clk);
    chk("w1_busy_drain", wr_busy, 1);
    wr_empty = 1;
    for (n = 0; n < 20 && wr_busy; n++) @(negedge clk);
    chk("w1_busy_fall", wr_busy, 0);
    chk("w1_pushes", wn, 16);
    chk("w1_cmds", cn, 1);
    chk("w1_instr", clog_i[0], 3'b000);
    chk("w1_addr", clog_a[0], 30'h123400);
    for (int i = 0; i < 16; i++)
      chk($sformatf("w1_d%0d", i), wlog[i], pat_w(i));

    // fill 0x0001
    do_clr();
    rd_lim = 16; raddr = 15'h0001; rd_req = 1;
    for (n = 0; n < 50 && !rd_busy; n++) @(negedge clk);
    chk("r1_busy_rise", rd_busy, 1);
    rd_req = 0;
    for (n = 0; n < 100 && rd_busy; n++) @(negedge clk);
    chk("r1_busy_fall", rd_busy, 0);
    chk("r1_err", rd_err, 0);
    chk("r1_cmds", cn, 1);
    chk("r1_instr", clog_i[0], 3'b001);
    chk("r1_addr", clog_a[0], 30'h100);
    chk("r1_writes", bn, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("r1_a%0d", i), blog_a[i], i);
      chk($sformatf("r1_d%0d", i), blog_d[i], pat_r(i));
    end

    // evict + fill together
    do_clr();
    rd_lim = 16; waddr = 15'h0042; raddr = 15'h0007;
    wr_req = 1; rd_req = 1;
    for (n = 0; n < 50 && !wr_busy; n++) @(negedge clk);
    chk("b2b_wr_first", wr_busy, 1);
    chk("b2b_rd_wait", rd_busy, 0);
    wr_req = 0;
    for (n = 0; n < 100 && wr_busy; n++) @(negedge clk);
    chk("b2b_wr_fall", wr_busy, 0);
    chk("b2b_handover", rd_busy, 1);
    chk("b2b_rcmd_now", {cmd_en, cmd_instr}, 4'b1001);
    chk("b2b_raddr", cmd_byte_addr, 30'h700);
    rd_req = 0;
    for (n = 0; n < 100 && rd_busy; n++) @(negedge clk);
    chk("b2b_rd_fall", rd_busy, 0);
    chk("b2b_cmds", cn, 2);
    chk("b2b_waddr", clog_a[0], 30'h4200);
    chk("b2b_pushes", wn, 16);
    chk("b2b_writes", bn, 16);

    // write FIFO back-pressure
    do_clr();
    waddr = 15'h0100; wr_req = 1;
    for (n = 0; n < 50 && !wr_busy; n++) @(negedge clk);
    wr_req = 0;
    for (n = 0; n < 50 && wn < 5; n++) @(negedge clk);
    chk("bp_started", wn, 5);
    wr_full = 1;
    repeat (3) @(negedge clk);
    chk("bp_stalled", wn, 5);
    wr_full = 0;
    for (n = 0; n < 100 && wr_busy; n++) @(negedge clk);
    chk("bp_busy_fall", wr_busy, 0);
    chk("bp_pushes", wn, 16);
    chk("bp_overflow", ovf, 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("bp_d%0d", i), wlog[i], pat_w(i));

    // read watchdog after 5 words
    do_clr();
    rd_lim = 5; raddr = 15'h0003; rd_req = 1;
    for (n = 0; n < 50 && !rd_busy; n++) @(negedge clk);
    rd_req = 0;
    for (n = 0; n < 50 && rd_idx < 5; n++) @(negedge clk);
    chk("wd_words", rd_idx, 5);
    for (n = 0; n < 100 && !rd_err; n++) @(negedge clk);
    chk("wd_cycles", n, 20);
    chk("wd_err", rd_err, 1);
    chk("wd_busy", rd_busy, 0);
    repeat (5) @(negedge clk);
    chk("wd_sticky", rd_err, 1);
    chk("wd_writes", bn, 5);

    // reset during fill word 7
    do_clr();
    rd_lim = 16; raddr = 15'h0005; rd_req = 1;
    for (n = 0; n < 50 && !rd_busy; n++) @(negedge clk);
    chk("rr_err_clr", rd_err, 0);
    rd_req = 0;
    for (n = 0; n < 50 && rd_idx < 7; n++) @(negedge clk);
    chk("rr_word7", rd_idx, 7);
    reset = 1;
    @(posedge clk);
    #1;
    chk("rr_strobes", {buf_en, wr_en, rd_en, cmd_en}, 0);
    chk("rr_busies", {wr_busy, rd_busy}, 0);
    @(negedge clk) reset = 0;
    repeat (10) @(negedge clk);
    chk("rr_no_pop", rd_idx, 7);
    chk("rr_no_write", bn, 7);
    chk("rr_idle", {wr_busy, rd_busy, rd_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
